led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Display-side consumer of the 4096 x 4-bit dual-port framebuffer. It walks the framebuffer read port and drives a 64x64 HUB75 LED panel with 1/32 scan. Each 4-bit pixel is an intensity, shown with 4-plane binary code modulation (BCM). It runs in the display clock domain, on the same clock that drives the framebuffer read port.

## Interface
- BASE_TIME, 64: on-time in clk cycles of bit plane 0; plane k is lit for BASE_TIME << k cycles.
- COLOR_MASK, 3'b111: {R,G,B} channels that display the intensity; a masked channel is held 0.
- clk  input  1  display clock; also clocks the framebuffer read port.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  scan enable.
- rd_addr  output  12  framebuffer read address = {row[5:0], col[5:0]}.
- rd_data  input  4  framebuffer read data, valid one clk after rd_addr changes.
- r1, g1, b1  output  1 each  upper-half (rows 0-31) color data.
- r2, g2, b2  output  1 each  lower-half (rows 32-63) color data.
- row_addr  output  5  panel row select A-E.
- panel_clk  output  1  panel shift clock; the panel samples on its rising edge.
- lat  output  1  panel latch strobe, active high.
- oe_n  output  1  panel output enable, active low.
- frame_start  output  1  one-cycle pulse at the start of row 0, plane 0.

## Operation
- Reset (reset_n low at a clk edge):
  - rd_addr=0, color outputs 0, row_addr=0, panel_clk=0, lat=0, oe_n=1, frame_start=0.
  - FSM goes to IDLE; row counter, plane counter, column counter and on-time counter clear to 0.
- States and transitions:
  - IDLE: oe_n=1. If en=1, pulse frame_start and go to SHIFT with row=0, plane=0.
  - SHIFT: 64 columns, 4 cycles per column (256 cycles). oe_n=1.
    - c0: rd_addr={0,row,col} (upper pixel).
    - c1: rd_addr={1,row,col} (lower pixel); capture upper rd_data.
    - c2: capture lower rd_data; drive r1 = COLOR_MASK[2] & upper[plane], g1/b1 likewise, r2/g2/b2 from lower; panel_clk=0.
    - c3: panel_clk=1, data held.
    - After col 63 c3, go to LATCH.
  - LATCH: 2 cycles, oe_n=1, panel_clk=0.
    - L0: row_addr=row, lat=1.
    - L1: lat=0.
    - Then go to SHOW.
  - SHOW: oe_n=0 for exactly BASE_TIME << plane cycles, then oe_n=1.
    - plane<3: plane+1, go to SHIFT.
    - plane=3: plane=0, row+1. Row 31 wraps to 0; frame_start pulses on the first SHIFT cycle of the new row 0.
    - en=0 at the last SHOW cycle: go to IDLE instead. Otherwise en is ignored mid-plane.
- Counters:
  - Column: 6 bits. Row: 5 bits, wraps 31->0. Plane: 2 bits.
  - On-time counter: at least 10 bits for the default; sized for BASE_TIME<<3.
- Registered outputs only; no combinational path from rd_data to a panel pin.

## Timing
- rd_data for an address issued at edge N is sampled at edge N+1. This tolerates a framebuffer read port that registers on the falling edge of clk.
- Per plane: 256 + 2 + (BASE_TIME<<plane) cycles. Per row with default: 4*258 + 960 = 1992 cycles. Per frame: 63744 cycles.
- panel_clk is high 1 cycle, low 3 cycles. Color data is stable from 1 cycle before the rising edge until 2 cycles after it.
- lat is never high while oe_n=0 or panel_clk=1. oe_n is never low outside SHOW.
- Reset mid-operation: the outputs take their reset values on that edge, regardless of state.
- en high in IDLE: the first SHIFT cycle is the next cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with en=1 -> oe_n=1, lat=0, panel_clk=0, rd_addr=0x000; after release, frame_start pulses once and SHIFT begins.
- Addressing: row 0 col 0 -> rd_addr 0x000 then 0x800. Row 5 col 63 -> 0x17F then 0x97F. Exactly 64 panel_clk rising edges per SHIFT.
- Pixel data: upper pixel 4'b1010 at (0,0), lower 4'b0101 at (32,0) -> first shifted bit r1=0, r2=1 in plane 0; r1=1, r2=0 in plane 1. With COLOR_MASK=3'b100, g and b stay 0.
- BCM: default parameters -> oe_n low runs of 64, 128, 256, 512 cycles per row. lat pulses once per plane, 1 cycle wide, with oe_n=1.
- Wrap: run 32 rows -> row_addr sequence 0..31 then 0; frame_start spacing 63744 cycles.
- en and reset: drop en during plane 2 SHOW -> plane 3 still displays, then IDLE with oe_n=1. Assert reset_n=0 mid-SHIFT -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/led_matrix_scan.sv
// HUB75 64x64 1/32-scan driver: walks the framebuffer read port and shows each 4-bit pixel with 4-plane BCM.
// Per plane: 256 shift cycles, 2 latch cycles, then BASE_TIME<<plane cycles with oe_n low.
module led_matrix_scan #(
  parameter int unsigned BASE_TIME  = 64,
  parameter logic [2:0]  COLOR_MASK = 3'b111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [11:0] rd_addr,
  input  logic [3:0]  rd_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic [4:0]  row_addr,
  output logic        panel_clk,
  output logic        lat,
  output logic        oe_n,
  output logic        frame_start
);

  localparam int CW = $clog2((BASE_TIME << 3) + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_SHOW} state_t;

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_ph, w_ph_nxt;
  logic [5:0]   r_col, w_col_nxt;
  logic [4:0]   r_row, w_row_nxt;
  logic [1:0]   r_plane, w_plane_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] w_show_len;
  logic         w_show_last;

  logic [3:0]   r_upper;
  logic [11:0]  r_rd_addr, w_rd_addr_nxt;
  logic [2:0]   r_rgb1, r_rgb2;
  logic [4:0]   r_row_addr;
  logic         r_pclk, r_lat, r_oe_n, r_fs;

  assign w_show_len  = CW'(BASE_TIME) << r_plane;
  assign w_show_last = (r_cnt == w_show_len - CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_plane_nxt = r_plane;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_SHIFT;
          w_ph_nxt    = 2'd0;
          w_col_nxt   = 6'd0;
          w_row_nxt   = 5'd0;
          w_plane_nxt = 2'd0;
        end
      end
      S_SHIFT: begin
        // ph and col wrap to 0 on their own, leaving LATCH ready at L0
        w_ph_nxt = r_ph + 2'd1;
        if (r_ph == 2'd3) begin
          w_col_nxt = r_col + 6'd1;
          if (r_col == 6'd63) w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_ph == 2'd0) begin
          w_ph_nxt = 2'd1;
        end else begin
          w_ph_nxt    = 2'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHOW;
        end
      end
      S_SHOW: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_show_last) begin
          if (r_plane != 2'd3) begin
            w_plane_nxt = r_plane + 2'd1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_plane_nxt = 2'd0;
            w_row_nxt   = r_row + 5'd1;
            w_state_nxt = en ? S_SHIFT : S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_rd_addr_nxt = r_rd_addr;
    if (w_state_nxt == S_SHIFT && w_ph_nxt == 2'd0) w_rd_addr_nxt = {1'b0, w_row_nxt, w_col_nxt};
    if (w_state_nxt == S_SHIFT && w_ph_nxt == 2'd1) w_rd_addr_nxt = {1'b1, w_row_nxt, w_col_nxt};
  end

  // Panel pins are registered from the next state so they line up with the cycle the state is in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ph       <= 2'd0;
      r_col      <= 6'd0;
      r_row      <= 5'd0;
      r_plane    <= 2'd0;
      r_cnt      <= '0;
      r_upper    <= 4'd0;
      r_rd_addr  <= 12'd0;
      r_rgb1     <= 3'd0;
      r_rgb2     <= 3'd0;
      r_row_addr <= 5'd0;
      r_pclk     <= 1'b0;
      r_lat      <= 1'b0;
      r_oe_n     <= 1'b1;
      r_fs       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ph      <= w_ph_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_plane   <= w_plane_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_pclk    <= (w_state_nxt == S_SHIFT) && (w_ph_nxt == 2'd3);
      r_lat     <= (w_state_nxt == S_LATCH) && (w_ph_nxt == 2'd0);
      r_oe_n    <= (w_state_nxt != S_SHOW);
      r_fs      <= (r_state != S_SHIFT) && (w_state_nxt == S_SHIFT) &&
                   (w_row_nxt == 5'd0) && (w_plane_nxt == 2'd0);
      if (w_state_nxt == S_LATCH && w_ph_nxt == 2'd0) r_row_addr <= w_row_nxt;
      // read data lags its address by one cycle: upper arrives end of c0, lower end of c1
      if (r_state == S_SHIFT && r_ph == 2'd0) r_upper <= rd_data;
      if (r_state == S_SHIFT && r_ph == 2'd1) begin
        r_rgb1 <= COLOR_MASK & {3{r_upper[r_plane]}};
        r_rgb2 <= COLOR_MASK & {3{rd_data[r_plane]}};
      end
    end
  end

  assign rd_addr     = r_rd_addr;
  assign {r1, g1, b1} = r_rgb1;
  assign {r2, g2, b2} = r_rgb2;
  assign row_addr    = r_row_addr;
  assign panel_clk   = r_pclk;
  assign lat         = r_lat;
  assign oe_n        = r_oe_n;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with a falling-edge framebuffer model and a negedge pin monitor.
module tb_led_matrix_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [11:0] rd_addr;
  logic [3:0]  rd_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic [4:0]  row_addr;
  logic        panel_clk, lat, oe_n, frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mem [0:4095];

  led_matrix_scan #(.BASE_TIME(64), .COLOR_MASK(3'b100)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .panel_clk(panel_clk), .lat(lat),
    .oe_n(oe_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // framebuffer read port registering on the falling edge
  always @(negedge clk) rd_data <= mem[rd_addr];

  // pin monitor
  int         cyc = 0;
  int         rise_cnt = 0;
  int         total_rises = 0;
  int         oe_run = 0;
  int         lat_wide = 0;
  int         lat_bad = 0;
  int         oe_bad = 0;
  logic       gb_seen = 1'b0;
  logic       prev_pclk = 1'b0;
  logic       prev_lat = 1'b0;
  int         fs_q[$];
  int         oe_q[$];
  int         rises_q[$];
  logic [4:0] row_q[$];
  logic [5:0] first_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      rise_cnt  <= 0;
      oe_run    <= 0;
      prev_pclk <= 1'b0;
      prev_lat  <= 1'b0;
    end else begin
      if (panel_clk && !prev_pclk) begin
        if (rise_cnt == 0) first_q.push_back({r1, g1, b1, r2, g2, b2});
        rise_cnt    <= rise_cnt + 1;
        total_rises <= total_rises + 1;
      end
      if (lat && !prev_lat) begin
        rises_q.push_back(rise_cnt);
        row_q.push_back(row_addr);
        rise_cnt <= 0;
      end
      if (lat && prev_lat) lat_wide <= lat_wide + 1;
      if (lat && (!oe_n || panel_clk)) lat_bad <= lat_bad + 1;
      if (!oe_n && panel_clk) oe_bad <= oe_bad + 1;
      if (!oe_n) oe_run <= oe_run + 1;
      else if (oe_run != 0) begin
        oe_q.push_back(oe_run);
        oe_run <= 0;
      end
      if (frame_start) fs_q.push_back(cyc);
      if (g1 || b1 || g2 || b2) gb_seen <= 1'b1;
      prev_pclk <= panel_clk;
      prev_lat  <= lat;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int guard;
    int bad;
    int snap;

    for (int i = 0; i < 4096; i++) mem[i] = 4'd0;
    mem[12'h000] = 4'b1010;
    mem[12'h800] = 4'b0101;

    // reset held for 3 edges with en high
    reset_n = 1'b0;
    en      = 1'b1;
    tick(3);
    check("rst_oe_n", 32'(oe_n), 32'd1);
    check("rst_lat", 32'(lat), 32'd0);
    check("rst_pclk", 32'(panel_clk), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'h000);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);

    reset_n = 1'b1;
    tick();
    check("start_fs", 32'(frame_start), 32'd1);
    check("c0_addr", 32'(rd_addr), 32'h000);
    tick();
    check("c1_addr", 32'(rd_addr), 32'h800);
    check("c1_fs", 32'(frame_start), 32'd0);
    tick();
    check("c2_pclk", 32'(panel_clk), 32'd0);
    check("c2_r1r2", 32'({r1, r2}), 32'b01);
    tick();
    check("c3_pclk", 32'(panel_clk), 32'd1);
    check("c3_oe_n", 32'(oe_n), 32'd1);
    tick();
    check("col1_addr", 32'(rd_addr), 32'h001);

    // row 5 col 63 addressing
    guard = 0;
    while (rd_addr !== 12'h17F && guard < 20000) begin tick(); guard++; end
    check("row5_found", 32'(guard < 20000), 32'd1);
    tick();
    check("row5_lower", 32'(rd_addr), 32'h97F);

    // run to the second frame_start
    guard = 0;
    while (fs_q.size() < 2 && guard < 70000) begin tick(); guard++; end
    check("fs_found", 32'(fs_q.size() >= 2), 32'd1);
    if (fs_q.size() >= 2) check("fs_spacing", 32'(fs_q[1] - fs_q[0]), 32'd63744);
    check("lat_count", 32'(row_q.size()), 32'd128);
    check("oe_run_count", 32'(oe_q.size()), 32'd128);

    bad = 0;
    for (int i = 0; i < row_q.size() && i < 128; i++)
      if (row_q[i] !== 5'(i / 4)) bad++;
    check("row_seq", 32'(bad), 32'd0);

    bad = 0;
    for (int i = 0; i < oe_q.size() && i < 128; i++)
      if (oe_q[i] != (64 << (i % 4))) bad++;
    check("bcm_runs", 32'(bad), 32'd0);
    if (oe_q.size() >= 4) check("bcm_plane3", 32'(oe_q[3]), 32'd512);

    bad = 0;
    for (int i = 0; i < rises_q.size(); i++)
      if (rises_q[i] != 64) bad++;
    check("pclk_per_shift", 32'(bad), 32'd0);

    check("first_bits_n", 32'(first_q.size() >= 2), 32'd1);
    if (first_q.size() >= 2) begin
      check("plane0_bits", 32'(first_q[0]), 32'b000100);
      check("plane1_bits", 32'(first_q[1]), 32'b100000);
    end
    check("gb_masked", 32'(gb_seen), 32'd0);
    check("lat_width", 32'(lat_wide), 32'd0);
    check("lat_overlap", 32'(lat_bad), 32'd0);
    check("oe_overlap", 32'(oe_bad), 32'd0);

    // drop en during plane 2 SHOW of row 0
    guard = 0;
    while (oe_q.size() < 130 && guard < 3000) begin tick(); guard++; end
    while (oe_n !== 1'b0 && guard < 3000) begin tick(); guard++; end
    check("plane2_show_found", 32'(guard < 3000), 32'd1);
    tick(10);
    en = 1'b0;
    guard = 0;
    while (oe_q.size() < 132 && guard < 3000) begin tick(); guard++; end
    check("en_drop_runs", 32'(oe_q.size()), 32'd132);
    if (oe_q.size() >= 132) begin
      check("en_drop_plane2", 32'(oe_q[130]), 32'd256);
      check("en_drop_plane3", 32'(oe_q[131]), 32'd512);
    end
    snap = total_rises;
    tick(300);
    check("idle_no_shift", 32'(total_rises - snap), 32'd0);
    check("idle_oe_n", 32'(oe_n), 32'd1);
    check("idle_no_lat", 32'(row_q.size()), 32'd132);
    if (row_q.size() >= 129) check("row_wrap", 32'(row_q[128]), 32'd0);

    // restart from IDLE, then reset mid-SHIFT
    en = 1'b1;
    tick();
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_addr", 32'(rd_addr), 32'h000);
    tick(3);
    check("restart_c3", 32'({panel_clk, r1, r2}), 32'b101);
    reset_n = 1'b0;
    tick();
    check("midrst_pclk", 32'(panel_clk), 32'd0);
    check("midrst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
    check("midrst_addr", 32'(rd_addr), 32'h000);
    check("midrst_ctl", 32'({oe_n, lat, frame_start}), 32'b100);
    check("midrst_row", 32'(row_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
